// File: rtl/enemy_column_gen_if.sv
// Column bus: frame/march/hit controls in from the formation, position/alive/score out.
// Master is the formation controller, slave is the column; no flow control, all strobes one cycle.
interface enemy_column_gen_if #(
  parameter int ROWS_P = 4
);
  logic              frame_i;
  logic              dir_i;
  logic              drop_i;
  logic              pointed_to_i;
  logic              hit_i;
  logic [2:0]        hit_row_i;
  logic [9:0]        left_pos_o;
  logic [9:0]        right_pos_o;
  logic [9:0]        top_pos_o;
  logic [ROWS_P-1:0] alive_o;
  logic [2:0]        bottom_row_o;
  logic [9:0]        bottom_y_o;
  logic              hit_ack_o;
  logic [3:0]        score_o;
  logic              expl_active_o;
  logic [2:0]        expl_row_o;
  logic              all_dead_o;

  modport master (
    output frame_i, dir_i, drop_i, pointed_to_i, hit_i, hit_row_i,
    input  left_pos_o, right_pos_o, top_pos_o, alive_o, bottom_row_o, bottom_y_o,
           hit_ack_o, score_o, expl_active_o, expl_row_o, all_dead_o
  );

  modport slave (
    input  frame_i, dir_i, drop_i, pointed_to_i, hit_i, hit_row_i,
    output left_pos_o, right_pos_o, top_pos_o, alive_o, bottom_row_o, bottom_y_o,
           hit_ack_o, score_o, expl_active_o, expl_row_o, all_dead_o
  );
endinterface

// File: rtl/enemy_column_gen.sv
// Invader column: alive mask, frame-driven march, row-addressed hits and a frame-timed explosion.
// Positions, hit ack and explosion update one cycle after their strobe; no backpressure.
module enemy_column_gen #(
  parameter int ROWS_P           = 4,
  parameter int LEFT_START_P     = 9,
  parameter int TOP_START_P      = 9,
  parameter int ROW_PITCH_P      = 40,
  parameter int ENEMY_W_P        = 32,
  parameter int ENEMY_H_P        = 32,
  parameter int STEP_PX_P        = 2,
  parameter int STEP_DIV_P       = 4,
  parameter int DROP_PX_P        = 8,
  parameter int EXPLODE_FRAMES_P = 8,
  parameter int SCREEN_W_P       = 640
) (
  input logic                clk_i,
  input logic                reset_ni,
  enemy_column_gen_if.slave  col
);

  localparam int DIV_W = (STEP_DIV_P > 1) ? $clog2(STEP_DIV_P) : 1;
  localparam int CNT_W = $clog2(EXPLODE_FRAMES_P + 1);
  localparam logic [10:0] X_MAX = 11'(SCREEN_W_P - ENEMY_W_P);

  typedef enum logic {IDLE, EXPLODE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        expl_row_q, expl_row_d;
  logic [DIV_W-1:0]  div_q;
  logic [9:0]        left_q, top_q;
  logic [ROWS_P-1:0] alive_q;
  logic              hit_ack_q;
  logic [3:0]        score_q;

  logic        move;
  logic        accept;
  logic [7:0]  alive_pad;
  logic [10:0] top_sum, left_inc;
  logic [3:0]  hit_score;
  logic [2:0]  bottom_row;
  logic [9:0]  row_off;

  assign move      = col.frame_i && (div_q == DIV_W'(STEP_DIV_P - 1));
  assign alive_pad = 8'(alive_q);
  assign accept    = col.hit_i && col.pointed_to_i &&
                     ({1'b0, col.hit_row_i} < 4'(ROWS_P)) && alive_pad[col.hit_row_i];
  assign top_sum   = {1'b0, top_q} + 11'(DROP_PX_P);
  assign left_inc  = {1'b0, left_q} + 11'(STEP_PX_P);
  assign hit_score = (col.hit_row_i < 3'd2) ? 4'd3 : (col.hit_row_i < 3'd4) ? 4'd2 : 4'd1;

  // March, alive mask and hit acknowledge
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_q     <= '0;
      left_q    <= 10'(LEFT_START_P);
      top_q     <= 10'(TOP_START_P);
      alive_q   <= '1;
      hit_ack_q <= 1'b0;
      score_q   <= 4'd0;
    end else begin
      if (col.frame_i) div_q <= move ? '0 : div_q + 1'b1;
      if (move) begin
        if (col.drop_i)
          top_q <= top_sum[10] ? 10'd1023 : top_sum[9:0];
        else if (col.dir_i)
          left_q <= (left_inc > X_MAX) ? X_MAX[9:0] : left_inc[9:0];
        else
          left_q <= (left_q < 10'(STEP_PX_P)) ? 10'd0 : left_q - 10'(STEP_PX_P);
      end
      if (accept) alive_q[col.hit_row_i[$clog2(ROWS_P+1)-1:0]] <= 1'b0;
      hit_ack_q <= accept;
      score_q   <= accept ? hit_score : 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      expl_row_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      expl_row_q <= expl_row_d;
    end
  end

  // A fresh hit always restarts the explosion, even on the frame that would end it
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    expl_row_d = expl_row_q;
    if (accept) begin
      state_d    = EXPLODE;
      cnt_d      = CNT_W'(EXPLODE_FRAMES_P);
      expl_row_d = col.hit_row_i;
    end else if (state_q == EXPLODE && col.frame_i) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) state_d = IDLE;
    end
  end

  always_comb begin
    bottom_row = 3'd0;
    for (int i = 0; i < ROWS_P; i++)
      if (alive_q[i]) bottom_row = 3'(i);
  end

  assign row_off = 10'(int'(bottom_row) * ROW_PITCH_P);

  assign col.left_pos_o    = left_q;
  assign col.right_pos_o   = left_q + 10'(ENEMY_W_P - 1);
  assign col.top_pos_o     = top_q;
  assign col.alive_o       = alive_q;
  assign col.bottom_row_o  = bottom_row;
  assign col.bottom_y_o    = top_q + row_off + 10'(ENEMY_H_P - 1);
  assign col.hit_ack_o     = hit_ack_q;
  assign col.score_o       = score_q;
  assign col.expl_active_o = (state_q == EXPLODE);
  assign col.expl_row_o    = expl_row_q;
  assign col.all_dead_o    = (alive_q == '0);

endmodule
